// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver: collects WIDTH strobed bits into po and
// holds the finished word under a valid/ready handshake.
module serial_word_receiver #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             serin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] po,
  output logic             out_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_po;
  logic [CW-1:0]    r_cnt;
  logic             r_overrun;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;

  // Next shift-register value; the shift direction is fixed by LSB_FIRST
  always_comb begin
    w_shifted = r_po;
    if (LSB_FIRST) begin
      w_shifted = {serin, r_po[WIDTH-1:1]};
    end else begin
      w_shifted = {r_po[WIDTH-2:0], serin};
    end
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Reception FSM: abort outranks start, which outranks bit_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_po      <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_SHIFT;
            r_po      <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (bit_valid) begin
            r_po  <= w_shifted;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Back-to-back restart wins over a bit arriving in the same cycle
          if (out_ready && start) begin
            r_state   <= S_SHIFT;
            r_po      <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
          end else begin
            if (bit_valid) begin
              r_overrun <= 1'b1;
            end
            if (out_ready) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign po        = r_po;
  assign bit_cnt   = r_cnt;
  assign overrun   = r_overrun;
  assign busy      = (r_state == S_SHIFT);
  assign out_valid = (r_state == S_HOLD);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: three configurations share one stimulus
// stream and are checked every cycle against a bit-list model.
module tb_serial_word_receiver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, bit_valid = 1'b0, serin = 1'b0, out_ready = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]  po_a, po_b;
  logic [15:0] po_c;
  logic [3:0]  cnt_a, cnt_b;
  logic [4:0]  cnt_c;
  logic        ov_a, ov_b, ov_c, bz_a, bz_b, bz_c, or_a, or_b, or_c;

  serial_word_receiver #(.WIDTH(8), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_valid(bit_valid),
    .serin(serin), .out_ready(out_ready), .po(po_a), .out_valid(ov_a),
    .busy(bz_a), .bit_cnt(cnt_a), .overrun(or_a));
  serial_word_receiver #(.WIDTH(8), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_valid(bit_valid),
    .serin(serin), .out_ready(out_ready), .po(po_b), .out_valid(ov_b),
    .busy(bz_b), .bit_cnt(cnt_b), .overrun(or_b));
  serial_word_receiver #(.WIDTH(16), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_valid(bit_valid),
    .serin(serin), .out_ready(out_ready), .po(po_c), .out_valid(ov_c),
    .busy(bz_c), .bit_cnt(cnt_c), .overrun(or_c));

  always #5 clk = ~clk;

  // Model: phase 0=idle 1=receiving 2=holding; bits[k] is the k-th received bit
  typedef struct packed {
    logic [1:0]  ph;
    logic [5:0]  cnt;
    logic [31:0] bits;
    logic [31:0] po;
    logic        ovr;
  } mst_t;

  mst_t m [3];
  int   mw [3] = '{8, 8, 16};
  bit   mlsb [3] = '{1'b1, 1'b0, 1'b1};

  function automatic mst_t nxt(input mst_t s, input int w, input bit lsb);
    mst_t n;
    n = s;
    if (abort) begin
      n.ph = 2'd0;
      n.cnt = 6'd0;
    end else if (s.ph == 2'd0) begin
      if (start) begin
        n = '0;
        n.ph = 2'd1;
      end
    end else if (s.ph == 2'd1) begin
      if (bit_valid) begin
        n.bits[s.cnt] = serin;
        n.cnt = s.cnt + 6'd1;
        n.po = 32'd0;
        // Word position of each bit follows from arrival order and count so far
        for (int j = 0; j < int'(n.cnt); j++) begin
          if (lsb) n.po[w - int'(n.cnt) + j] = n.bits[j];
          else     n.po[int'(n.cnt) - 1 - j] = n.bits[j];
        end
        if (int'(n.cnt) == w) n.ph = 2'd2;
      end
    end else begin
      if (out_ready && start) begin
        n = '0;
        n.ph = 2'd1;
      end else begin
        if (bit_valid) n.ovr = 1'b1;
        if (out_ready) n.ph = 2'd0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) m[i] <= '0;
      else     m[i] <= nxt(m[i], mw[i], mlsb[i]);
    end
  end

  task automatic cmp(input string name, input int i, input logic [31:0] p,
                     input logic v, input logic b, input logic [5:0] c, input logic o);
    checks++;
    if (p !== m[i].po || v !== (m[i].ph == 2'd2) || b !== (m[i].ph == 2'd1) ||
        c !== m[i].cnt || o !== m[i].ovr) begin
      failures++;
      $display("FAIL %s t=%0t got po=%h v=%b busy=%b cnt=%0d ovr=%b want po=%h v=%b busy=%b cnt=%0d ovr=%b",
               name, $time, p, v, b, c, o, m[i].po, m[i].ph == 2'd2, m[i].ph == 2'd1,
               m[i].cnt, m[i].ovr);
    end
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_w8_lsb", 0, 32'(po_a), ov_a, bz_a, 6'(cnt_a), or_a);
      cmp("model_w8_msb", 1, 32'(po_b), ov_b, bz_b, 6'(cnt_b), or_b);
      cmp("model_w16_lsb", 2, 32'(po_c), ov_c, bz_c, 6'(cnt_c), or_c);
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic ab, input logic bv, input logic si, input logic rdy);
    start = st; abort = ab; bit_valid = bv; serin = si; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] v, input int lo, input int hi);
    for (int j = lo; j <= hi; j++) cyc(1'b0, 1'b0, 1'b1, v[j], 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    lit("reset_po", 32'(po_a), 32'h0);
    lit("reset_flags", {28'd0, ov_a, bz_a, or_a, |cnt_a}, 32'h0);

    // Bits 1,0,1,1,0,0,1,0 in arrival order
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_004D, 0, 6);
    lit("valid_before_last", 32'(ov_a), 32'h0);
    send(32'h0000_004D, 7, 7);
    lit("lsb_word", 32'(po_a), 32'h4D);
    lit("msb_word", 32'(po_b), 32'hB2);
    lit("hold_valid_busy", {30'd0, ov_a, bz_a}, 32'h2);
    lit("hold_cnt", 32'(cnt_a), 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lit("release_valid", 32'(ov_b), 32'h0);
    lit("release_po_kept", 32'(po_b), 32'hB2);

    // Gapped word 0x3C with three idle cycles after the 3rd bit
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_003C, 0, 2);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("gap_cnt", 32'(cnt_a), 32'd3);
    end
    send(32'h0000_003C, 3, 6);
    lit("gap_not_yet_valid", 32'(ov_a), 32'h0);
    send(32'h0000_003C, 7, 7);
    lit("gap_word", 32'(po_a), 32'h3C);

    // Bits arriving while the word waits in HOLD
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    lit("overrun_po", 32'(po_a), 32'h3C);
    lit("overrun_flag", 32'(or_a), 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    lit("b2b_state", {29'd0, bz_a, ov_a, or_a}, 32'h4);
    lit("b2b_cnt", 32'(cnt_a), 32'd0);
    send(32'h0000_00FF, 0, 7);
    lit("b2b_word", 32'(po_a), 32'hFF);

    // Abort after four bits, then a fresh word
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_000F, 0, 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    lit("abort_cnt", 32'(cnt_a), 32'd0);
    lit("abort_flags", {30'd0, ov_a, bz_a}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0096, 0, 7);
    lit("after_abort_word", 32'(po_a), 32'h96);

    // Asynchronous reset between clock edges, mid-word
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_00FF, 0, 2);
    #2 rst = 1'b1;
    #1;
    lit("async_rst_po", 32'(po_a), 32'h0);
    lit("async_rst_cnt", 32'(cnt_a), 32'd0);
    lit("async_rst_flags", {29'd0, bz_a, ov_a, or_a}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 16-bit word sent LSB first
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_A5C3, 0, 15);
    lit("w16_word", 32'(po_c), 32'hA5C3);
    lit("w16_valid_cnt", {26'd0, ov_c, cnt_c}, {26'd0, 1'b1, 5'd16});
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
Parametrised serial-to-parallel receiver: collects WIDTH bits from a strobed serial line into a word, then holds the word under a valid/ready handshake. Internal FSM replaces the external count/shift enables of the previous fixed 8-bit input stage. Supports configurable shift order, abort, back-to-back words and overrun detection. Sits between the serial input pins and the datapath that consumes operand words.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
LSB_FIRST, 1, 1 = first received bit lands in po[0]; 0 = first received bit lands in po[WIDTH-1].
CW, $clog2(WIDTH+1), bit counter width (derived; do not override).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin word reception; accepted in IDLE, or in HOLD when out_ready=1.
abort  input  1  synchronous cancel of the current word.
bit_valid  input  1  serin carries a valid bit this cycle.
serin  input  1  serial data bit.
out_ready  input  1  consumer accepts po this cycle.
po  output  WIDTH  assembled word (shift register contents).
out_valid  output  1  po holds a complete word.
busy  output  1  reception in progress (state SHIFT).
bit_cnt  output  CW  bits received in the current word.
overrun  output  1  sticky: a bit arrived while a word was pending in HOLD.

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. On reset: state IDLE, po=0, bit_cnt=0, out_valid=0, busy=0, overrun=0.
- All other updates occur on the rising clk edge. Priority: rst > abort > start > bit_valid.
- States: IDLE, SHIFT, HOLD. Outputs are decoded from registered state only: busy=(SHIFT), out_valid=(HOLD).
- IDLE:
  - start=1: go to SHIFT; clear po and bit_cnt to 0; clear overrun.
  - bit_valid is ignored.
- SHIFT:
  - On bit_valid=1, shift in one bit and increment bit_cnt.
  - LSB_FIRST=1: po <= {serin, po[WIDTH-1:1]}.
  - LSB_FIRST=0: po <= {po[WIDTH-2:0], serin}.
  - On bit_valid=1 with bit_cnt==WIDTH-1, go to HOLD. bit_cnt becomes WIDTH. out_valid asserts in the cycle after the last bit; latency is 1 clk.
  - bit_valid=0: no change, no timeout.
  - start is ignored.
- HOLD:
  - po and bit_cnt are stable.
  - out_ready=1 and start=1: go to SHIFT; clear po and bit_cnt; clear overrun. This is the back-to-back case, with no IDLE cycle.
  - out_ready=1 and start=0: go to IDLE; po is retained, bit_cnt is retained.
  - out_ready=0: stay in HOLD; start is ignored.
  - bit_valid=1 in HOLD: the bit is discarded, po is unchanged, and overrun is set to 1. The bit is discarded even if the handshake completes in the same cycle.
- abort=1, any state: go to IDLE; clear bit_cnt to 0; out_valid drops next cycle; po is retained; overrun is unchanged. The same-cycle bit_valid/start are ignored.
- bit_cnt never exceeds WIDTH; there is no wrap-around.
- Reset mid-word: an immediate return to reset values with no partial output.

Test Plan:
- WIDTH=8, LSB_FIRST=1. Apply start, then bits 1,0,1,1,0,0,1,0 on consecutive bit_valid cycles -> po=8'h4D. out_valid=1 one cycle after the 8th bit. busy=0 and bit_cnt=8 in HOLD.
- WIDTH=8, LSB_FIRST=0. Apply the same bit sequence -> po=8'hB2. Then set out_ready=1 with start=0 -> IDLE next cycle and out_valid=0.
- Gapped input. Insert 3 idle cycles (bit_valid=0) after the 3rd bit -> bit_cnt holds at 3 during the gap. Final word is correct; out_valid timing is relative to the 8th valid bit only.
- HOLD with out_ready=0 for 5 cycles, pulsing bit_valid with serin=1 -> po is unchanged and overrun=1. Then out_ready=1 with start=1 -> SHIFT, bit_cnt=0, overrun=0, and the next word 8'hFF is received correctly.
- abort after 4 bits -> IDLE next cycle, bit_cnt=0, out_valid stays 0. A fresh start with 8 bits yields a correct word with no stale bits.
- Assert rst asynchronously mid-word, between clock edges -> all outputs reach reset values immediately. WIDTH=16 regression: bits 0xA5C3 sent LSB-first -> po=16'hA5C3.
